// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline: EX/MEM destination
// scoreboard, load-use and MDU stalls, and ID-stage operand forwarding selects.

module hazard_src_hit #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_use,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_rd,
  output logic              hit_ex,
  output logic              hit_mem
);
  logic live;
  assign live    = rs_use && (rs != '0);
  assign hit_ex  = live && ex_wr && (ex_rd == rs);
  assign hit_mem = live && mem_wr && (mem_rd == rs);
endmodule

module hazard_ctrl_unit #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int FWD_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1use,
  input  logic              id_rs2use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_optype,
  input  logic              id_mdu,
  input  logic              id_flush,
  output logic              stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mdu_busy
);
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [3:0] MDU_LD  = 4'(MDU_LAT - 1);
  localparam logic       NO_FWD  = (FWD_EN == 0);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [1:0]        optype;
    logic              mdu;
  } sb_t;

  sb_t        ex_q, mem_q, id_ent;
  logic [3:0] cnt_q;
  logic       ex_wr, mem_wr, id_live, raw_stall, any_ex, any_mem;

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0]             rs_use, hit_ex, hit_mem;
  logic [1:0][1:0]        sel;

  assign id_ent   = '{valid: 1'b1, rd: id_rd, optype: id_optype, mdu: id_mdu};
  assign ex_wr    = ex_q.valid  && (ex_q.optype  == OP_ALU || ex_q.optype  == OP_LOAD);
  assign mem_wr   = mem_q.valid && (mem_q.optype == OP_ALU || mem_q.optype == OP_LOAD);
  assign rs       = {id_rs2, id_rs1};
  assign rs_use   = {id_rs2use, id_rs1use};
  assign mdu_busy = (cnt_q != '0);
  assign id_live  = id_valid && !id_flush;

  for (genvar i = 0; i < 2; i++) begin : g_src
    hazard_src_hit #(.REG_AW(REG_AW)) u_hit (
      .rs(rs[i]), .rs_use(rs_use[i]),
      .ex_wr(ex_wr), .ex_rd(ex_q.rd),
      .mem_wr(mem_wr), .mem_rd(mem_q.rd),
      .hit_ex(hit_ex[i]), .hit_mem(hit_mem[i])
    );
  end

  assign any_ex  = |hit_ex;
  assign any_mem = |hit_mem;

  always_comb begin
    raw_stall = (any_ex && ex_q.optype == OP_LOAD) ||
                (any_ex && ex_q.mdu && mdu_busy) ||
                (NO_FWD && (any_ex || any_mem));
    stall     = mdu_busy || (id_live && raw_stall);
    ex_bubble = stall && !mdu_busy;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 2'b00;
      if (!NO_FWD && !stall) begin
        if (hit_ex[i])       sel[i] = 2'b01;
        else if (hit_mem[i]) sel[i] = (mem_q.optype == OP_LOAD) ? 2'b11 : 2'b10;
      end
    end
    fwd_a = sel[0];
    fwd_b = sel[1];
  end

  // While the MDU counts down the op stays in EX and MEM sees bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else if (mdu_busy) begin
      mem_q <= '0;
      cnt_q <= cnt_q - 4'd1;
    end else begin
      mem_q <= ex_q;
      if (stall || !id_live) begin
        ex_q <= '0;
      end else begin
        ex_q <= id_ent;
        if (id_mdu) cnt_q <= MDU_LD;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one forwarding instance and one FWD_EN=0 instance.
module tb_hazard_ctrl_unit;
  localparam int AW = 5;

  logic          clk, rst_n;
  logic          id_valid, id_rs1use, id_rs2use, id_mdu, id_flush;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]    id_optype;
  logic          stall, ex_bubble, mdu_busy;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall2, ex_bubble2, mdu_busy2;
  logic [1:0]    fwd_a2, fwd_b2;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit #(.REG_AW(AW), .MDU_LAT(4), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1use(id_rs1use), .id_rs2use(id_rs2use), .id_rd(id_rd), .id_optype(id_optype),
    .id_mdu(id_mdu), .id_flush(id_flush), .stall(stall), .ex_bubble(ex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(mdu_busy));

  hazard_ctrl_unit #(.REG_AW(AW), .MDU_LAT(4), .FWD_EN(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1use(id_rs1use), .id_rs2use(id_rs2use), .id_rd(id_rd), .id_optype(id_optype),
    .id_mdu(id_mdu), .id_flush(id_flush), .stall(stall2), .ex_bubble(ex_bubble2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .mdu_busy(mdu_busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic u1, input logic u2, input logic [AW-1:0] rd,
                        input logic [1:0] op, input logic m, input logic f);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1use = u1; id_rs2use = u2;
    id_rd = rd; id_optype = op; id_mdu = m; id_flush = f;
    #1;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic drain();
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    checks++; if ({fwd_a, fwd_b, ex_bubble, mdu_busy} !== 6'b0) begin errors++; $display("FAIL rst_outs got %b want 000000", {fwd_a, fwd_b, ex_bubble, mdu_busy}); end
    tick(); rst_n = 1'b1;
    set_id(1, 1, 2, 1, 1, 9, 2'b01, 1, 0);   // mul x9
    tick();
    idle();
    tick();                                   // counter now 2
    checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", mdu_busy); end
    rst_n = 1'b0;
    set_id(1, 9, 0, 1, 0, 10, 2'b01, 0, 0);
    checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", mdu_busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", stall); end
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL rst_mid_fwd got %b want 00", fwd_a); end
    tick(); rst_n = 1'b1; #1;
    checks++; if ({stall, fwd_a} !== 3'b000) begin errors++; $display("FAIL rst_ex_empty got %b want 000", {stall, fwd_a}); end
    idle(); tick();
    set_id(1, 9, 0, 1, 0, 10, 2'b01, 0, 0);
    checks++; if ({stall, fwd_a} !== 3'b000) begin errors++; $display("FAIL rst_mem_empty got %b want 000", {stall, fwd_a}); end
    drain();
  endtask

  task automatic test_alu_fwd();
    set_id(1, 1, 2, 1, 1, 5, 2'b01, 0, 0);   // add x5
    tick();
    set_id(1, 5, 6, 1, 1, 0, 2'b00, 0, 0);   // beq x5,x6
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL alu_ex_fwd_a got %b want 01", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL alu_ex_fwd_b got %b want 00", fwd_b); end
    checks++; if ({stall, ex_bubble} !== 2'b00) begin errors++; $display("FAIL alu_ex_stall got %b want 00", {stall, ex_bubble}); end
    tick();
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL alu_mem_fwd_a got %b want 10", fwd_a); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1, 2, 0, 1, 0, 7, 2'b10, 0, 0);   // lw x7
    tick();
    set_id(1, 7, 7, 1, 1, 8, 2'b01, 0, 0);   // add x8,x7,x7
    checks++; if ({stall, ex_bubble} !== 2'b11) begin errors++; $display("FAIL ld_stall got %b want 11", {stall, ex_bubble}); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL ld_stall_fwd got %b want 0000", {fwd_a, fwd_b}); end
    tick();
    checks++; if ({stall, ex_bubble} !== 2'b00) begin errors++; $display("FAIL ld_release got %b want 00", {stall, ex_bubble}); end
    checks++; if ({fwd_a, fwd_b} !== 4'b1111) begin errors++; $display("FAIL ld_fwd got %b want 1111", {fwd_a, fwd_b}); end
    drain();
  endtask

  task automatic test_x0_flush();
    set_id(1, 2, 0, 1, 0, 0, 2'b10, 0, 0);   // lw x0
    tick();
    set_id(1, 0, 0, 1, 1, 8, 2'b01, 0, 0);
    checks++; if ({stall, fwd_a, fwd_b} !== 5'b0) begin errors++; $display("FAIL x0_nohit got %b want 00000", {stall, fwd_a, fwd_b}); end
    set_id(1, 2, 0, 1, 0, 7, 2'b10, 0, 0);   // lw x7
    tick();
    set_id(1, 7, 0, 1, 0, 7, 2'b01, 0, 1);   // add x7,x7 squashed
    checks++; if ({stall, ex_bubble} !== 2'b00) begin errors++; $display("FAIL flush_stall got %b want 00", {stall, ex_bubble}); end
    tick();
    set_id(1, 7, 0, 1, 0, 10, 2'b01, 0, 0);
    checks++; if ({stall, fwd_a} !== 3'b011) begin errors++; $display("FAIL flush_ex_inv got %b want 011", {stall, fwd_a}); end
    drain();
  endtask

  task automatic test_mdu();
    set_id(1, 1, 2, 1, 1, 11, 2'b01, 0, 0);  // add x11
    tick();
    set_id(1, 1, 2, 1, 1, 9, 2'b01, 1, 0);   // mul x9
    tick();
    set_id(1, 9, 11, 1, 1, 10, 2'b01, 0, 0); // add x10,x9,x11
    for (int c = 0; c < 3; c++) begin
      if (c == 1) id_flush = 1'b1;
      #1;
      checks++; if ({mdu_busy, stall, ex_bubble} !== 3'b110) begin errors++; $display("FAIL mdu_busy_c%0d got %b want 110", c, {mdu_busy, stall, ex_bubble}); end
      checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL mdu_busy_fwd_c%0d got %b want 00", c, fwd_a); end
      id_flush = 1'b0;
      tick();
    end
    checks++; if ({mdu_busy, stall} !== 2'b00) begin errors++; $display("FAIL mdu_done got %b want 00", {mdu_busy, stall}); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0100) begin errors++; $display("FAIL mdu_fwd got %b want 0100", {fwd_a, fwd_b}); end
    tick();
    set_id(1, 9, 0, 1, 0, 12, 2'b01, 0, 0);
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL mdu_mem_fwd got %b want 10", fwd_a); end
    drain();
  endtask

  task automatic test_no_fwd();
    idle();
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
    set_id(1, 1, 2, 1, 1, 5, 2'b01, 0, 0);   // add x5
    tick();
    set_id(1, 5, 0, 1, 0, 6, 2'b01, 0, 0);   // add x6,x5
    checks++; if ({stall2, ex_bubble2, fwd_a2} !== 4'b1100) begin errors++; $display("FAIL nf_ex got %b want 1100", {stall2, ex_bubble2, fwd_a2}); end
    tick();
    checks++; if ({stall2, ex_bubble2, fwd_a2} !== 4'b1100) begin errors++; $display("FAIL nf_mem got %b want 1100", {stall2, ex_bubble2, fwd_a2}); end
    tick();
    checks++; if ({stall2, ex_bubble2, fwd_a2} !== 4'b0000) begin errors++; $display("FAIL nf_go got %b want 0000", {stall2, ex_bubble2, fwd_a2}); end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_x0_flush();
    test_mdu();
    test_no_fwd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RV32 pipeline. Successor to the purely combinational per-instruction hazard_optype/rs1use/rs2use decode.
- Keeps a shadow scoreboard of in-flight destinations in EX and MEM.
- Generates stall/bubble and ID-stage operand forwarding selects; branches compare in ID.
- Adds a multi-cycle MDU occupancy counter in EX and a forwarding-disable mode.

Parameters:
- REG_AW, 5, register address width (4 for RV32E).
- MDU_LAT, 4, cycles an MDU op occupies EX; legal range 1..15.
- FWD_EN, 1, 1 enables forwarding; 0 resolves every RAW by stalling.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_AW  ID source 1.
- id_rs2  in  REG_AW  ID source 2.
- id_rs1use  in  1  rs1 read by ID instruction.
- id_rs2use  in  1  rs2 read by ID instruction.
- id_rd  in  REG_AW  ID destination.
- id_optype  in  2  00 none, 01 ALU, 10 LOAD, 11 STORE.
- id_mdu  in  1  ID instruction is a multi-cycle MDU op (optype 01).
- id_flush  in  1  squash ID instruction (taken branch/jump).
- stall  out  1  hold PC, IF/ID and ID.
- ex_bubble  out  1  insert NOP into EX next edge.
- fwd_a  out  2  rs1 source: 00 regfile, 01 EX result, 10 MEM ALU result, 11 MEM load data.
- fwd_b  out  2  rs2 source, same encoding.
- mdu_busy  out  1  MDU counter non-zero.

Behaviour:
- Scoreboard entries EX and MEM each hold {valid, rd, optype, mdu}. Writers are optype 01 or 10; rd==0 is never a writer.
- Reset (async, rst_n low): all entries invalid, counter 0. Combinational outputs then read stall=0, ex_bubble=0, fwd_a=fwd_b=00, mdu_busy=0. Reset mid-MDU drops the op immediately.
- hit_X(rs) = rsNuse & X.valid & writer & X.rd==rs & rs!=0. The EX hit takes priority over the MEM hit.
- Stall causes (OR):
  - mdu_busy.
  - EX hit by a LOAD.
  - EX hit by an MDU op while counter!=0.
  - FWD_EN=0 and any EX or MEM hit.
- stall and ex_bubble are qualified by id_valid & !id_flush, except for the mdu_busy term.
- Forwarding when FWD_EN=1 and no stall:
  - EX hit gives 01.
  - Otherwise MEM hit gives 10 if MEM optype is ALU, or 11 if it is LOAD.
  - Otherwise 00.
- When FWD_EN=0, or during any stall, fwd outputs are 00.
- WB is not tracked: the regfile is write-first.
- Each rising edge, MEM <= EX unless counter!=0; in that case MEM <= invalid and EX is held.
- EX <= invalid if stall or id_flush or !id_valid. Otherwise EX <= ID fields.
- ex_bubble = stall & !mdu_busy.
- Counter:
  - When an MDU op enters EX, the counter loads MDU_LAT-1.
  - Counter decrements while non-zero.
  - MDU_LAT=1 behaves exactly as ALU.
- Simultaneous events:
  - id_flush during a load-use stall squashes the ID instruction and clears the stall in the same cycle.
  - id_flush does not clear mdu_busy.

Test Plan:
- Reset: rst_n=0 mid-MDU with counter=2 -> mdu_busy=0, stall=0, fwd=00 while reset is held; EX and MEM invalid after release.
- ALU forward: add x5 in EX, ID `beq x5,x6` -> fwd_a=01, fwd_b=00, stall=0. Next cycle (x5 in MEM) -> fwd_a=10.
- Load-use: lw x7 in EX, ID `add x8,x7,x7` -> stall=1, ex_bubble=1 for one cycle. Next cycle fwd_a=fwd_b=11, stall=0.
- x0 / flush: lw x0 in EX with ID using x0 -> no stall. lw x7 in EX with ID user plus id_flush=1 -> stall=0, EX next = invalid.
- MDU, MDU_LAT=4: mul x9 enters EX -> mdu_busy=1 for 3 cycles, stall=1, MEM receives 3 bubbles. A dependent ID op then gets fwd=01 on the 4th cycle.
- FWD_EN=0: add x5 in EX, ID uses x5 -> stall for 2 cycles (EX then MEM), fwd=00 throughout, proceeds on the 3rd cycle.
